paddle_encoder_decoder: RTL and testbench

Receive-side decoder for one player's rotary-encoder paddle control: synchronises and debounces the quadrature A/B lines and the push switch, tracks the quadrature state, and maintains a saturating paddle position. One instance per player sits between the player GPIO inputs (A, B, switch) and the VGA/game logic, which consumes `o_pos`, `o_press` and the step strobes.

---
 rtl/pong_pkg.sv | 36 +++
 rtl/input_debounce.sv | 39 +++
 rtl/paddle_encoder_decoder.sv | 95 +++++++++
 tb/tb_paddle_encoder_decoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the paddle input path: quadrature states and
// default playfield limits / debounce length.
package pong_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_POS_MIN         = 0;
  localparam int DEF_POS_MAX         = 400;
  localparam int DEF_POS_RESET       = 200;

  // Each state encodes the last accepted {A,B}.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_e;

  function automatic quad_e cw_next(input quad_e s);
    case (s)
      Q00:     return Q01;
      Q01:     return Q11;
      Q11:     return Q10;
      default: return Q00;
    endcase
  endfunction

  function automatic quad_e ccw_next(input quad_e s);
    case (s)
      Q00:     return Q10;
      Q10:     return Q11;
      Q11:     return Q01;
      default: return Q00;
    endcase
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchroniser followed by a stable-bit debouncer: a change is
// accepted only after the synced value differs for DEBOUNCE_CYCLES cycles.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = pong_pkg::DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic synced,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic [CNT_W-1:0] cnt;

  // Synchroniser carries no reset so it keeps tracking the pin during reset.
  always_ff @(posedge clk) begin
    meta   <= raw;
    synced <= meta;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= synced;
      cnt    <= '0;
    end else if (synced == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= synced;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/paddle_encoder_decoder.sv
// One player's paddle: debounced quadrature decode into a clamped position,
// plus debounced push-switch level and press strobe.
module paddle_encoder_decoder
  import pong_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int POS_WIDTH       = 10,
  parameter int POS_MIN         = DEF_POS_MIN,
  parameter int POS_MAX         = DEF_POS_MAX,
  parameter int POS_RESET       = DEF_POS_RESET,
  parameter int STEP            = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 i_rst,
  input  logic                 i_a,
  input  logic                 i_b,
  input  logic                 i_sw,
  output logic [POS_WIDTH-1:0] o_pos,
  output logic                 o_step,
  output logic                 o_dir,
  output logic                 o_press,
  output logic                 o_sw_level,
  output logic                 o_err,
  output logic [1:0]           quad_state
);

  localparam logic signed [POS_WIDTH:0]  STEP_S  = (POS_WIDTH+1)'(STEP);
  localparam logic signed [POS_WIDTH:0]  MIN_S   = (POS_WIDTH+1)'(POS_MIN);
  localparam logic signed [POS_WIDTH:0]  MAX_S   = (POS_WIDTH+1)'(POS_MAX);
  localparam logic [POS_WIDTH-1:0]       MIN_V   = POS_WIDTH'(POS_MIN);
  localparam logic [POS_WIDTH-1:0]       MAX_V   = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0]       RESET_V = POS_WIDTH'(POS_RESET);

  logic a_sync, b_sync, sw_sync;
  logic a_stable, b_stable, sw_stable;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(CLOCK_50), .rst(i_rst), .raw(i_a), .synced(a_sync), .stable(a_stable)
  );
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(CLOCK_50), .rst(i_rst), .raw(i_b), .synced(b_sync), .stable(b_stable)
  );
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw (
    .clk(CLOCK_50), .rst(i_rst), .raw(i_sw), .synced(sw_sync), .stable(sw_stable)
  );

  quad_e                  state;
  logic [1:0]             ab;
  logic signed [POS_WIDTH:0] sum_inc, sum_dec;
  logic [POS_WIDTH-1:0]   pos_inc, pos_dec;

  assign ab         = {a_stable, b_stable};
  assign quad_state = state;

  // Extra bit keeps the overshoot past either limit visible before clamping.
  always_comb begin
    sum_inc = $signed({1'b0, o_pos}) + STEP_S;
    sum_dec = $signed({1'b0, o_pos}) - STEP_S;
    pos_inc = (sum_inc > MAX_S) ? MAX_V : sum_inc[POS_WIDTH-1:0];
    pos_dec = (sum_dec < MIN_S) ? MIN_V : sum_dec[POS_WIDTH-1:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (i_rst) begin
      // Load from the synchroniser, matching what the debouncers load now.
      state      <= quad_e'({a_sync, b_sync});
      o_pos      <= RESET_V;
      o_step     <= 1'b0;
      o_dir      <= 1'b0;
      o_err      <= 1'b0;
      o_press    <= 1'b0;
      o_sw_level <= ~sw_sync;
    end else begin
      o_step     <= 1'b0;
      o_err      <= 1'b0;
      o_sw_level <= ~sw_stable;
      o_press    <= ~sw_stable & ~o_sw_level;
      if (ab != state) begin
        state <= quad_e'(ab);
        if (quad_e'(ab) == cw_next(state)) begin
          o_step <= 1'b1;
          o_dir  <= 1'b1;
          o_pos  <= pos_inc;
        end else if (quad_e'(ab) == ccw_next(state)) begin
          o_step <= 1'b1;
          o_dir  <= 1'b0;
          o_pos  <= pos_dec;
        end else begin
          o_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_paddle_encoder_decoder.sv
// Scoreboarded bench for paddle_encoder_decoder with a short debounce.
module tb_paddle_encoder_decoder;

  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       i_rst = 1'b1, i_a = 1'b1, i_b = 1'b1, i_sw = 1'b1;
  logic [9:0] o_pos;
  logic       o_step, o_dir, o_press, o_sw_level, o_err;
  logic [1:0] quad_state;

  paddle_encoder_decoder #(
    .DEBOUNCE_CYCLES(D), .POS_WIDTH(10), .POS_MIN(0), .POS_MAX(20),
    .POS_RESET(10), .STEP(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .i_rst(i_rst), .i_a(i_a), .i_b(i_b), .i_sw(i_sw),
    .o_pos(o_pos), .o_step(o_step), .o_dir(o_dir), .o_press(o_press),
    .o_sw_level(o_sw_level), .o_err(o_err), .quad_state(quad_state)
  );

  // clock / reset
  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // scoreboard: events are {kind[1:0], dir, pos[9:0]}; kind 1=step 2=err 3=press
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  logic        mon_en = 1'b0;
  int          n_cmp = 0, n_fail = 0;

  int         m_pos;
  logic       m_dir;
  logic [1:0] m_state;
  logic [1:0] cw_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      if (o_step)  obs_q.push_back({2'd1, o_dir, o_pos});
      if (o_err)   obs_q.push_back({2'd2, o_dir, o_pos});
      if (o_press) obs_q.push_back({2'd3, o_dir, o_pos});
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_reset(input logic [1:0] st);
    m_state = st;
    m_pos   = 10;
    m_dir   = 1'b0;
  endtask

  task automatic model_apply(input logic a, input logic b);
    logic [1:0] nv;
    int qi;
    nv = {a, b};
    if (nv == m_state) return;
    qi = 0;
    for (int k = 0; k < 4; k++) if (cw_seq[k] == m_state) qi = k;
    if ((nv ^ m_state) == 2'b11) begin
      exp_q.push_back({2'd2, m_dir, 10'(m_pos)});
    end else if (nv == cw_seq[(qi + 1) % 4]) begin
      m_pos = (m_pos + 4 > 20) ? 20 : m_pos + 4;
      m_dir = 1'b1;
      exp_q.push_back({2'd1, 1'b1, 10'(m_pos)});
    end else begin
      m_pos = (m_pos - 4 < 0) ? 0 : m_pos - 4;
      m_dir = 1'b0;
      exp_q.push_back({2'd1, 1'b0, 10'(m_pos)});
    end
    m_state = nv;
  endtask

  task automatic move(input logic a, input logic b);
    model_apply(a, b);
    i_a = a;
    i_b = b;
    tick(10);
  endtask

  task automatic do_reset(input logic a, input logic b);
    i_rst = 1'b1;
    i_a   = a;
    i_b   = b;
    i_sw  = 1'b1;
    tick(6);
    i_rst = 1'b0;
    model_reset({a, b});
    tick(1);
  endtask

  task automatic test_reset;
    int start, lat;
    logic seen;
    do_reset(1'b1, 1'b1);
    n_cmp++; if (o_pos !== 10'd10) begin n_fail++; $display("FAIL reset_pos got %0d required 10", o_pos); end
    n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b required 0", o_err); end
    n_cmp++; if (o_press !== 1'b0) begin n_fail++; $display("FAIL reset_press got %b required 0", o_press); end
    n_cmp++; if (o_sw_level !== 1'b0) begin n_fail++; $display("FAIL reset_sw_level got %b required 0", o_sw_level); end
    n_cmp++; if (o_step !== 1'b0) begin n_fail++; $display("FAIL reset_step got %b required 0", o_step); end
    n_cmp++; if (o_dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir got %b required 0", o_dir); end
    mon_en = 1'b1;
    model_apply(1'b1, 1'b0);
    start = cyc;
    i_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (o_step) seen = 1'b1;
    end
    lat = cyc - start;
    n_cmp++; if (!seen || lat != 7) begin n_fail++; $display("FAIL first_latency got %0d seen=%b required 7", lat, seen); end
    n_cmp++; if (o_pos !== 10'd14 || o_dir !== 1'b1) begin n_fail++; $display("FAIL first_step got pos=%0d dir=%b required pos=14 dir=1", o_pos, o_dir); end
    tick(6);
    while (exp_q.size() != 0) begin
      logic [12:0] e, o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL reset_event got %h required %h", o, e); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_extra got %0d events required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_cw_ccw;
    do_reset(1'b0, 1'b0);
    move(1'b0, 1'b1); move(1'b1, 1'b1); move(1'b1, 1'b0); move(1'b0, 1'b0);
    move(1'b1, 1'b0); move(1'b1, 1'b1); move(1'b0, 1'b1); move(1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      logic [12:0] e, o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL cw_ccw_event got %h required %h", o, e); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL cw_ccw_extra got %0d events required 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (o_pos !== 10'd4) begin n_fail++; $display("FAIL cw_ccw_final_pos got %0d required 4", o_pos); end
  endtask

  task automatic test_glitch;
    i_a = 1'b1; tick(3); i_a = 1'b0; tick(12);
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_extra got %0d events required 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (o_pos !== 10'(m_pos) || quad_state !== m_state) begin n_fail++; $display("FAIL glitch_hold got pos=%0d st=%b required pos=%0d st=%b", o_pos, quad_state, m_pos, m_state); end
    // a 4-cycle pulse is accepted, and its return is accepted too
    model_apply(1'b1, 1'b0);
    model_apply(1'b0, 1'b0);
    i_a = 1'b1; tick(4); i_a = 1'b0; tick(15);
    while (exp_q.size() != 0) begin
      logic [12:0] e, o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL pulse4_event got %h required %h", o, e); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL pulse4_extra got %0d events required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_illegal;
    move(1'b1, 1'b1);
    n_cmp++; if (quad_state !== 2'b11) begin n_fail++; $display("FAIL illegal_state got %b required 11", quad_state); end
    move(1'b1, 1'b0);
    move(1'b0, 1'b0);
    while (exp_q.size() != 0) begin
      logic [12:0] e, o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL illegal_event got %h required %h", o, e); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL illegal_extra got %0d events required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_switch;
    exp_q.push_back({2'd3, m_dir, 10'(m_pos)});
    i_sw = 1'b0; tick(9);
    n_cmp++; if (o_sw_level !== 1'b1) begin n_fail++; $display("FAIL sw_level_pressed got %b required 1", o_sw_level); end
    tick(1); i_sw = 1'b1; tick(12);
    n_cmp++; if (o_sw_level !== 1'b0) begin n_fail++; $display("FAIL sw_level_released got %b required 0", o_sw_level); end
    for (int k = 0; k < 4; k++) begin
      i_sw = 1'b0; tick(2); i_sw = 1'b1; tick(2);
    end
    tick(10);
    n_cmp++; if (o_sw_level !== 1'b0) begin n_fail++; $display("FAIL sw_bounce_level got %b required 0", o_sw_level); end
    exp_q.push_back({2'd3, m_dir, 10'(m_pos)});
    i_sw = 1'b0; tick(12); i_sw = 1'b1; tick(12);
    while (exp_q.size() != 0) begin
      logic [12:0] e, o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL press_event got %h required %h", o, e); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL press_extra got %0d events required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0, 1'b0);
    move(1'b0, 1'b1);
    move(1'b1, 1'b1);
    n_cmp++; if (o_pos !== 10'd18) begin n_fail++; $display("FAIL mid_setup_pos got %0d required 18", o_pos); end
    i_b = 1'b0; tick(3);
    i_rst = 1'b1; tick(1);
    n_cmp++; if (o_pos !== 10'd10) begin n_fail++; $display("FAIL mid_reset_pos got %0d required 10", o_pos); end
    n_cmp++; if (o_step !== 1'b0) begin n_fail++; $display("FAIL mid_reset_step got %b required 0", o_step); end
    i_rst = 1'b0;
    model_reset(2'b10);
    tick(15);
    n_cmp++; if (o_pos !== 10'd10) begin n_fail++; $display("FAIL mid_after_pos got %0d required 10", o_pos); end
    while (exp_q.size() != 0) begin
      logic [12:0] e, o;
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front(); else o = '1;
      n_cmp++; if (o !== e) begin n_fail++; $display("FAIL mid_event got %h required %h", o, e); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_extra got %0d events required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // final report
  initial begin
    test_reset;
    test_cw_ccw;
    test_glitch;
    test_illegal;
    test_switch;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
